// File: rtl/mdu_controller_pkg.sv
// Shared encodings for the multiply/divide sequencing controller: instruction
// field codes and FSM state encoding.
package mdu_controller_pkg;

  // R-type opcode and MDU funct codes
  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] FtMfhi  = 6'b010000;
  localparam logic [5:0] FtMthi  = 6'b010001;
  localparam logic [5:0] FtMflo  = 6'b010010;
  localparam logic [5:0] FtMtlo  = 6'b010011;
  localparam logic [5:0] FtMult  = 6'b011000;
  localparam logic [5:0] FtMultu = 6'b011001;
  localparam logic [5:0] FtDiv   = 6'b011010;
  localparam logic [5:0] FtDivu  = 6'b011011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } state_e;

  function automatic logic [5:0] ir_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [5:0] ir_ft(input logic [31:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/mdu_controller_md_decode.sv
// Combinational classifier of one 32-bit instruction into MDU instruction classes.
// div/divu are recognised only when MDU_DIV_EN is defined.
module mdu_controller_md_decode
  import mdu_controller_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_md_start,
  output logic        is_div,
  output logic        is_signed,
  output logic        is_mfhi,
  output logic        is_mflo,
  output logic        is_mthi,
  output logic        is_mtlo,
  output logic        is_md_any
);

  logic [5:0] ft;
  logic       is_r;
  logic       is_mult;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^ir[25:6];

  // Field compare against the MDU funct codes
  always_comb begin
    ft      = ir_ft(ir);
    is_r    = (ir_op(ir) == OpR);
    is_mult = is_r & ((ft == FtMult) | (ft == FtMultu));
`ifdef MDU_DIV_EN
    is_div  = is_r & ((ft == FtDiv) | (ft == FtDivu));
`else
    is_div  = 1'b0;
`endif
    is_md_start = is_mult | is_div;
    // Only meaningful together with is_md_start
    is_signed   = is_md_start & ((ft == FtMult) | (ft == FtDiv));
    is_mfhi     = is_r & (ft == FtMfhi);
    is_mflo     = is_r & (ft == FtMflo);
    is_mthi     = is_r & (ft == FtMthi);
    is_mtlo     = is_r & (ft == FtMtlo);
    is_md_any   = is_md_start | is_mfhi | is_mflo | is_mthi | is_mtlo;
  end

endmodule

// File: rtl/mdu_controller.sv
// E-stage multiply/divide sequencer: launches fixed-latency mult/div, owns HI/LO,
// services mthi/mtlo/mfhi/mflo and requests a D-stage stall on MDU collisions.
// Optional feature: define MDU_DIV_EN to build div/divu support.
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_D,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic        MDStall,
  output logic [31:0] MDout
);

  localparam logic [3:0] MulLoad = 4'(MULT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done;
  logic [31:0] hi_q, lo_q, a_q, b_q;
  logic        sgn_q;
  logic [63:0] prod;

  logic e_start, e_div, e_signed, e_mfhi, e_mflo, e_mthi, e_mtlo, e_any;
  logic d_start, d_div, d_signed, d_mfhi, d_mflo, d_mthi, d_mtlo, d_any;
  logic unused_class;
  logic [3:0] unused_div_load;

  assign unused_class    = e_any ^ d_start ^ d_div ^ d_signed ^ d_mfhi ^ d_mflo ^ d_mthi ^ d_mtlo;
  assign unused_div_load = 4'(DIV_CYCLES - 1);

  mdu_controller_md_decode u_dec_e (
    .ir          (IR_E),
    .is_md_start (e_start),
    .is_div      (e_div),
    .is_signed   (e_signed),
    .is_mfhi     (e_mfhi),
    .is_mflo     (e_mflo),
    .is_mthi     (e_mthi),
    .is_mtlo     (e_mtlo),
    .is_md_any   (e_any)
  );

  mdu_controller_md_decode u_dec_d (
    .ir          (IR_D),
    .is_md_start (d_start),
    .is_div      (d_div),
    .is_signed   (d_signed),
    .is_mfhi     (d_mfhi),
    .is_mflo     (d_mflo),
    .is_mthi     (d_mthi),
    .is_mtlo     (d_mtlo),
    .is_md_any   (d_any)
  );

  // State and cycle counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load the counter on launch, count down, finish when it hits zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
`ifdef MDU_DIV_EN
          if (e_div) begin
            state_d = StDiv;
            cnt_d   = unused_div_load;
          end else begin
            state_d = StMul;
            cnt_d   = MulLoad;
          end
`else
          state_d = StMul;
          cnt_d   = MulLoad;
`endif
        end
      end
      StMul: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef MDU_DIV_EN
      StDiv: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs: launch, busy, stall request and HI/LO read port (no bypass)
  always_comb begin
    Start   = e_start & (state_q == StIdle);
    Busy    = (state_q != StIdle);
    MDStall = (Start | Busy) & d_any;
    MDout   = e_mfhi ? hi_q : (e_mflo ? lo_q : '0);
  end

  // Sign- or zero-extend to 64 bits; the truncated product is then exact
  always_comb begin
    prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  end

`ifdef MDU_DIV_EN
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic        a_neg, b_neg;

  // Sign-magnitude divide: quotient truncates toward zero, remainder follows dividend
  always_comb begin
    a_neg = sgn_q & a_q[31];
    b_neg = sgn_q & b_q[31];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end
`else
  logic unused_div;
  assign unused_div = e_div;
`endif

  // Operand latch and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else begin
      if (Start) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= e_signed;
      end
      if (done) begin
        if (state_q == StMul) begin
          {hi_q, lo_q} <= prod;
        end
`ifdef MDU_DIV_EN
        // Divide by zero leaves HI/LO untouched
        if ((state_q == StDiv) && (b_q != 32'd0)) begin
          hi_q <= rem;
          lo_q <= quot;
        end
`endif
      end else if (state_q == StIdle) begin
        if (e_mthi) hi_q <= A;
        if (e_mtlo) lo_q <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller with a scoreboard of expected HI/LO reads.
// Follows MDU_DIV_EN the same way the design does.
module tb_mdu_controller;

  localparam logic [5:0] TbMfhi  = 6'b010000;
  localparam logic [5:0] TbMthi  = 6'b010001;
  localparam logic [5:0] TbMflo  = 6'b010010;
  localparam logic [5:0] TbMtlo  = 6'b010011;
  localparam logic [5:0] TbMult  = 6'b011000;
  localparam logic [5:0] TbMultu = 6'b011001;
  localparam logic [5:0] TbDiv   = 6'b011010;
  localparam logic [5:0] TbDivu  = 6'b011011;
  localparam logic [5:0] TbAddu  = 6'b100001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_e, ir_d, a, b;
  logic        start, busy, md_stall;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hi_m, lo_m;

  mdu_controller #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .IR_E    (ir_e),
    .IR_D    (ir_d),
    .A       (a),
    .B       (b),
    .Start   (start),
    .Busy    (busy),
    .MDStall (md_stall),
    .MDout   (md_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] ft);
    return {6'b000000, 5'd8, 5'd9, 5'd10, 5'd0, ft};
  endfunction

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y,
                                            input bit sgn);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    sb.push_back('{{tag, "_hi"}, hi});
    sb.push_back('{{tag, "_lo"}, lo});
    hi_m = hi;
    lo_m = lo;
  endtask

  // Read HI then LO through mfhi/mflo and compare against the scoreboard
  task automatic read_hilo();
    exp_t e;
    ir_e = rtype(TbMfhi);
    #1;
    e = sb.pop_front();
    check(e.tag, md_out, e.val);
    tick();
    ir_e = rtype(TbMflo);
    #1;
    e = sb.pop_front();
    check(e.tag, md_out, e.val);
    tick();
    ir_e = '0;
  endtask

  // Launch one operation from IDLE and measure how long Busy stays high
  task automatic run_op(input string tag, input logic [5:0] ft, input logic [31:0] op_a,
                        input logic [31:0] op_b, input int exp_cycles);
    int n;
    n    = 0;
    ir_e = rtype(ft);
    a    = op_a;
    b    = op_b;
    #1;
    check({tag, "_start"}, {31'd0, start}, 32'd1);
    tick();
    ir_e = '0;
    a    = 32'hA5A5_5A5A;
    b    = 32'h0F0F_F0F0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_busy_len"}, n, exp_cycles);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb;
    int          n;
    logic        div_stall_exp;
`ifdef MDU_DIV_EN
    div_stall_exp = 1'b1;
`else
    div_stall_exp = 1'b0;
`endif

    reset = 1'b1;
    ir_e  = '0;
    ir_d  = '0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    check("rst_mdout", md_out, 32'd0);
    push_hilo("rst", 32'd0, 32'd0);
    read_hilo();

    run_op("mult", TbMult, 32'hFFFF_FFFE, 32'd3, 5);
    push_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    read_hilo();

    run_op("multu", TbMultu, 32'hFFFF_FFFE, 32'd3, 5);
    push_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    read_hilo();

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("mult_rnd", TbMult, ra, rb, 5);
      p = mul_model(ra, rb, 1'b1);
      push_hilo("mult_rnd", p[63:32], p[31:0]);
      read_hilo();
      run_op("multu_rnd", TbMultu, ra, rb, 5);
      p = mul_model(ra, rb, 1'b0);
      push_hilo("multu_rnd", p[63:32], p[31:0]);
      read_hilo();
    end

`ifdef MDU_DIV_EN
    run_op("div", TbDiv, 32'hFFFF_FFF9, 32'd2, 10);
    push_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    read_hilo();
    run_op("div0", TbDiv, 32'd1234, 32'd0, 10);
    push_hilo("div0", hi_m, lo_m);
    read_hilo();
    run_op("divu", TbDivu, 32'hFFFF_FFF9, 32'd7, 10);
    push_hilo("divu", 32'hFFFF_FFF9 % 32'd7, 32'hFFFF_FFF9 / 32'd7);
    read_hilo();
    run_op("div_pos_neg", TbDiv, 32'd100, 32'hFFFF_FFF9, 10);
    push_hilo("div_pos_neg", 32'd2, 32'hFFFF_FFF2);
    read_hilo();
`else
    // Without divider support div is not an MDU instruction
    ir_e = rtype(TbDiv);
    a    = 32'd77;
    b    = 32'd5;
    #1;
    check("nodiv_start", {31'd0, start}, 32'd0);
    tick();
    ir_e = '0;
    #1;
    check("nodiv_busy", {31'd0, busy}, 32'd0);
    push_hilo("nodiv", hi_m, lo_m);
    read_hilo();
`endif

    // mflo held in D behind a starting mult
    ir_e = rtype(TbMult);
    ir_d = rtype(TbMflo);
    a    = 32'd6;
    b    = 32'd7;
    #1;
    n = 0;
    while (md_stall === 1'b1 && n < 40) begin
      n++;
      tick();
      ir_e = '0;
      #1;
    end
    check("stall_len", n, 32'd6);
    check("stall_release_busy", {31'd0, busy}, 32'd0);
    ir_d = '0;
    push_hilo("stall_mult", 32'd0, 32'd42);
    read_hilo();

    // Back-to-back mult: the second starts as soon as the stall releases
    ir_e = rtype(TbMult);
    ir_d = rtype(TbMult);
    a    = 32'd3;
    b    = 32'd5;
    #1;
    n = 0;
    while (md_stall === 1'b1 && n < 40) begin
      n++;
      tick();
      ir_e = '0;
      #1;
    end
    ir_d = '0;
    run_op("b2b", TbMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    push_hilo("b2b", 32'd0, 32'd1);
    read_hilo();

    // mthi/mtlo while idle
    ir_e = rtype(TbMthi);
    a    = 32'h1234_5678;
    tick();
    ir_e = rtype(TbMtlo);
    a    = 32'h8765_4321;
    tick();
    ir_e = '0;
    push_hilo("mthi_mtlo", 32'h1234_5678, 32'h8765_4321);
    read_hilo();

    // During Busy: addu in D no stall, mthi ignored, second mult ignored, div in D per build
    ir_e = rtype(TbMultu);
    a    = 32'h0001_0000;
    b    = 32'h0001_0003;
    #1;
    check("busy_mix_start", {31'd0, start}, 32'd1);
    tick();
    ir_e = rtype(TbMthi);
    ir_d = rtype(TbAddu);
    a    = 32'hDEAD_BEEF;
    #1;
    check("busy_mix_busy", {31'd0, busy}, 32'd1);
    check("addu_no_stall", {31'd0, md_stall}, 32'd0);
    tick();
    ir_e = rtype(TbMult);
    ir_d = rtype(TbDiv);
    #1;
    check("busy_no_restart", {31'd0, start}, 32'd0);
    check("div_in_d_stall", {31'd0, md_stall}, {31'd0, div_stall_exp});
    tick();
    ir_e = '0;
    ir_d = '0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("busy_mix_len", n, 32'd3);
    push_hilo("busy_mix", 32'h0000_0001, 32'h0003_0000);
    read_hilo();

    // Reset in the 3rd Busy cycle aborts and clears HI/LO
`ifdef MDU_DIV_EN
    ir_e = rtype(TbDiv);
`else
    ir_e = rtype(TbMult);
`endif
    a = 32'd1000;
    b = 32'd3;
    tick();
    ir_e = '0;
    tick();
    tick();
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    push_hilo("mid_reset", 32'd0, 32'd0);
    read_hilo();
    run_op("post_reset", TbMult, 32'd9, 32'hFFFF_FFFF, 5);
    push_hilo("post_reset", 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    read_hilo();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
